// File: rtl/dmux4way_pkg.sv
// Shared types and helpers for the 4-way dispatcher.
// Holds channel indices, the holding-state enum, the round-robin search and the one-hot decode.
package dmux4way_pkg;

    typedef logic [1:0] chan_t;

    localparam chan_t CH_A = 2'd0;
    localparam chan_t CH_B = 2'd1;
    localparam chan_t CH_C = 2'd2;
    localparam chan_t CH_D = 2'd3;

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

    // First enabled channel after ptr, searching ptr+1 .. ptr+4.
    // The downward loop lets the nearest candidate overwrite the farther ones.
    // An all-zero mask returns ptr; callers gate on mask != 0.
    function automatic chan_t rr_next(chan_t ptr, logic [3:0] mask);
        chan_t c;
        rr_next = ptr;
        for (int i = 4; i >= 1; i--) begin
            c = ptr + chan_t'(i);
            if (mask[c]) begin
                rr_next = c;
            end
        end
    endfunction

    // Plain 1-to-4 demux of a single bit.
    function automatic logic [3:0] dmux4way(logic in, chan_t sel);
        dmux4way = 4'b0000;
        dmux4way[sel] = in;
    endfunction

endpackage

// File: rtl/dmux4way_dispatcher_rr_pick4.sv
// Combinational round-robin picker over four channels.
// Ports: ptr (last grant), mask (enables) -> tgt (next grant), any (some channel enabled).
module rr_pick4
    import dmux4way_pkg::*;
(
    input  chan_t       ptr,
    input  logic [3:0]  mask,
    output chan_t       tgt,
    output logic        any
);

    assign tgt = rr_next(ptr, mask);
    assign any = |mask;

endmodule

// File: rtl/dmux4way_dispatcher.sv
// Valid/ready dispatcher steering each beat to one of four lanes.
// Ports: clk, reset (sync, high); mode/sel/en_mask pick the lane; in_valid/in_data/in_ready
// upstream; out_valid (one-hot)/out_data/out_ready downstream; busy; cnt_a..cnt_d per-lane drains.
module dmux4way_dispatcher
    import dmux4way_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             mode,
    input  logic [1:0]       sel,
    input  logic [3:0]       en_mask,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             in_ready,
    output logic [3:0]       out_valid,
    output logic [WIDTH-1:0] out_data,
    input  logic [3:0]       out_ready,
    output logic             busy,
    output logic [CNT_W-1:0] cnt_a,
    output logic [CNT_W-1:0] cnt_b,
    output logic [CNT_W-1:0] cnt_c,
    output logic [CNT_W-1:0] cnt_d
);

    state_t           state;
    chan_t            tgt_q;
    chan_t            rr_ptr;
    logic [WIDTH-1:0] data_q;

    chan_t            rr_tgt;
    logic             rr_any;
    chan_t            new_tgt;
    logic             can_sel;
    logic             out_hs;
    logic             in_hs;

    rr_pick4 u_pick (
        .ptr  (rr_ptr),
        .mask (en_mask),
        .tgt  (rr_tgt),
        .any  (rr_any)
    );

    assign busy    = (state == FULL);
    assign out_hs  = busy & out_ready[tgt_q];
    assign can_sel = mode | rr_any;
    // A drain frees the slot in the same cycle, so accept can ride on it.
    assign in_ready = can_sel & (~busy | out_hs);
    assign in_hs    = in_valid & in_ready;
    assign new_tgt  = mode ? chan_t'(sel) : rr_tgt;

    assign out_valid = dmux4way(busy, tgt_q);
    assign out_data  = busy ? data_q : '0;

    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= EMPTY;
            tgt_q  <= CH_A;
            data_q <= '0;
            rr_ptr <= CH_D;
        end else begin
            if (in_hs) begin
                state  <= FULL;
                tgt_q  <= new_tgt;
                data_q <= in_data;
                if (!mode) begin
                    rr_ptr <= rr_tgt;
                end
            end else if (out_hs) begin
                state <= EMPTY;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_a <= '0;
            cnt_b <= '0;
            cnt_c <= '0;
            cnt_d <= '0;
        end else if (out_hs) begin
            unique case (tgt_q)
                CH_A: cnt_a <= cnt_a + 1'b1;
                CH_B: cnt_b <= cnt_b + 1'b1;
                CH_C: cnt_c <= cnt_c + 1'b1;
                CH_D: cnt_d <= cnt_d + 1'b1;
            endcase
        end
    end

endmodule

// File: tb/tb_dmux4way_dispatcher.sv
// Self-checking bench for dmux4way_dispatcher.
// Directed scenarios then random traffic, all checked against a lane-level reference model.
module tb_dmux4way_dispatcher;

    logic       clk = 1'b0;
    logic       reset;
    logic       mode;
    logic [1:0] sel;
    logic [3:0] en_mask;
    logic       in_valid;
    logic [7:0] in_data;
    logic       in_ready;
    logic [3:0] out_valid;
    logic [7:0] out_data;
    logic [3:0] out_ready;
    logic       busy;
    logic [7:0] cnt_a, cnt_b, cnt_c, cnt_d;

    int total = 0;
    int bad   = 0;

    // reference model: one optional held beat, last rr grant, per-lane counts
    bit m_held;
    int m_tgt;
    int m_data;
    int m_ptr;
    int m_cnt [4];

    always #5 clk = ~clk;

    dmux4way_dispatcher #(.WIDTH(8), .CNT_W(8)) dut (
        .clk       (clk),
        .reset     (reset),
        .mode      (mode),
        .sel       (sel),
        .en_mask   (en_mask),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_ready (out_ready),
        .busy      (busy),
        .cnt_a     (cnt_a),
        .cnt_b     (cnt_b),
        .cnt_c     (cnt_c),
        .cnt_d     (cnt_d)
    );

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_held = 0;
        m_tgt  = 0;
        m_data = 0;
        m_ptr  = 3;
        for (int k = 0; k < 4; k++) m_cnt[k] = 0;
    endtask

    // One clock: check outputs at the falling edge, then advance the model across the rising edge.
    task automatic cycle();
        bit can, drain, rdy, take;
        int pick;
        @(negedge clk);
        can   = mode || (en_mask != 4'b0000);
        drain = m_held && out_ready[m_tgt];
        rdy   = can && (!m_held || drain);
        take  = in_valid && rdy;
        chk("in_ready",  {31'd0, in_ready}, {31'd0, rdy});
        chk("busy",      {31'd0, busy}, {31'd0, m_held});
        chk("out_valid", {28'd0, out_valid}, m_held ? (32'd1 << m_tgt) : 32'd0);
        chk("out_data",  {24'd0, out_data}, m_held ? m_data : 0);
        chk("cnt_a", {24'd0, cnt_a}, m_cnt[0]);
        chk("cnt_b", {24'd0, cnt_b}, m_cnt[1]);
        chk("cnt_c", {24'd0, cnt_c}, m_cnt[2]);
        chk("cnt_d", {24'd0, cnt_d}, m_cnt[3]);
        pick = m_ptr;
        if (!mode) begin
            for (int i = 4; i >= 1; i--) begin
                if (en_mask[(m_ptr + i) % 4]) pick = (m_ptr + i) % 4;
            end
        end else begin
            pick = sel;
        end
        @(posedge clk);
        #1;
        if (reset) begin
            model_reset();
        end else begin
            if (drain) m_cnt[m_tgt] = (m_cnt[m_tgt] + 1) % 256;
            if (take) begin
                m_held = 1;
                m_tgt  = pick;
                m_data = in_data;
                if (!mode) m_ptr = pick;
            end else if (drain) begin
                m_held = 0;
            end
        end
    endtask

    task automatic run(int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    initial begin
        reset     = 1'b1;
        mode      = 1'b0;
        sel       = 2'b00;
        en_mask   = 4'b1111;
        in_valid  = 1'b0;
        in_data   = 8'h00;
        out_ready = 4'b0000;
        model_reset();
        @(posedge clk);
        #1;

        // 1: reset held, then released
        run(2);
        reset = 1'b0;
        cycle();
        chk("t1_in_ready", {31'd0, in_ready}, 32'd1);

        // 2: round robin, continuous stream, no bubbles
        out_ready = 4'b1111;
        in_valid  = 1'b1;
        for (int i = 1; i <= 5; i++) begin
            in_data = 8'(i * 8'h11);
            cycle();
        end
        in_valid = 1'b0;
        cycle();
        chk("t2_cnt_a", {24'd0, cnt_a}, 32'd2);
        chk("t2_cnt_d", {24'd0, cnt_d}, 32'd1);

        // 3: sparse mask, then mask off while holding
        en_mask = 4'b1010;
        in_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            in_data = 8'h60 + 8'(i);
            cycle();
        end
        chk("t3_last_d", {28'd0, out_valid}, 32'b1000);
        out_ready = 4'b0000;
        in_data   = 8'h70;
        cycle();
        en_mask = 4'b0000;
        cycle();
        chk("t3_mask0_rdy", {31'd0, in_ready}, 32'd0);
        out_ready = 4'b1111;
        run(2);
        chk("t3_drained", {31'd0, busy}, 32'd0);

        // 4: fixed lane c, stalled consumer, wrong-lane ready ignored
        in_valid  = 1'b0;
        mode      = 1'b1;
        sel       = 2'b10;
        out_ready = 4'b0000;
        in_valid  = 1'b1;
        in_data   = 8'hAA;
        cycle();
        in_valid = 1'b0;
        mode     = 1'b0;
        sel      = 2'b01;
        en_mask  = 4'b0001;
        run(5);
        chk("t4_hold", {28'd0, out_valid}, 32'b0100);
        out_ready = 4'b1000;
        run(2);
        out_ready = 4'b0100;
        run(2);

        // 5: back-to-back in fixed mode, then reset while full
        mode      = 1'b1;
        sel       = 2'b01;
        out_ready = 4'b0010;
        in_valid  = 1'b1;
        in_data   = 8'hB1;
        cycle();
        in_data = 8'hB2;
        cycle();
        chk("t5_busy", {31'd0, busy}, 32'd1);
        out_ready = 4'b0000;
        in_data   = 8'hB3;
        cycle();
        reset = 1'b1;
        cycle();
        reset = 1'b0;
        in_valid = 1'b0;
        cycle();
        chk("t5_rst_ov", {28'd0, out_valid}, 32'd0);

        // 6: counter wrap on lane a
        mode      = 1'b1;
        sel       = 2'b00;
        out_ready = 4'b1111;
        in_valid  = 1'b1;
        for (int i = 0; i < 256; i++) begin
            in_data = 8'(i);
            cycle();
        end
        in_valid = 1'b0;
        run(2);
        chk("t6_wrap", {24'd0, cnt_a}, 32'd0);
        chk("t6_cnt_b", {24'd0, cnt_b}, 32'd0);

        // random traffic
        for (int i = 0; i < 600; i++) begin
            reset     = ($urandom_range(0, 79) == 0);
            mode      = 1'($urandom_range(0, 3) == 0);
            sel       = 2'($urandom);
            en_mask   = ($urandom_range(0, 9) == 0) ? 4'b0000 : 4'($urandom);
            in_valid  = 1'($urandom);
            in_data   = 8'($urandom);
            out_ready = 4'($urandom);
            cycle();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
